// File: rtl/sequence_generator.sv
// sequence_generator: bit-serial pattern transmitter with load handshake, repeat passes and framing strobes
module sequence_generator #(
  parameter int WIDTH = 16,
  parameter int LW = 5,
  parameter int RW = 4,
  parameter int GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic [RW-1:0]    rpt,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             done
);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n, pat, pat_n;
  logic [LW-1:0] len_r, len_n, idx, idx_n, eff_len;
  logic [RW-1:0] pass, pass_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic done_n, last;
  assign load_ready = (state == S_IDLE) && !rst;
  assign eff_len = (len == '0 || len > LW'(WIDTH)) ? LW'(WIDTH) : len;
  assign last = idx == len_r - LW'(1);
  // next-state: each pass restarts from the retained pattern so repeats resend identical bits
  always_comb begin
    state_n = state;
    sh_n = sh;
    pat_n = pat;
    len_n = len_r;
    idx_n = idx;
    pass_n = pass;
    gcnt_n = gcnt;
    done_n = 1'b0;
    case (state)
      S_IDLE:
        if (load_valid) begin
          state_n = S_SHIFT;
          sh_n = pattern;
          pat_n = pattern;
          len_n = eff_len;
          idx_n = '0;
          pass_n = rpt;
        end
      S_SHIFT:
        if (abort) state_n = S_IDLE;
        else if (!last) begin
          sh_n = sh >> 1;
          idx_n = idx + LW'(1);
        end else if (pass != '0) begin
          pass_n = pass - RW'(1);
          idx_n = '0;
          sh_n = pat;
          gcnt_n = '0;
          state_n = GAP == 0 ? S_SHIFT : S_GAP;
        end else begin
          state_n = S_IDLE;
          done_n = 1'b1;
        end
      S_GAP:
        if (abort) state_n = S_IDLE;
        else if (gcnt == GW'(GAP == 0 ? 0 : GAP - 1)) state_n = S_SHIFT;
        else gcnt_n = gcnt + GW'(1);
      default: state_n = S_IDLE;
    endcase
  end
  // state register; outputs are registered from the next-state view so they align with the bit being sent
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sh <= '0;
      pat <= '0;
      len_r <= '0;
      idx <= '0;
      pass <= '0;
      gcnt <= '0;
      x <= 1'b0;
      x_valid <= 1'b0;
      sof <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      pat <= pat_n;
      len_r <= len_n;
      idx <= idx_n;
      pass <= pass_n;
      gcnt <= gcnt_n;
      x <= (state_n == S_SHIFT) && sh_n[0];
      x_valid <= state_n == S_SHIFT;
      sof <= (state_n == S_SHIFT) && (idx_n == '0);
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: randomized scoreboard bench for sequence_generator
module tb_sequence_generator;
  localparam int W = 16;
  localparam int G = 2;
  typedef struct {int cyc; bit dn; bit xb; bit sb;} exp_t;
  logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, abort = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [4:0] len = '0;
  logic [3:0] rpt = '0;
  logic load_ready, x, x_valid, sof, done;
  exp_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0, act_s = 0, act_e = 0, ec = 0, det = 0;
  logic [3:0] dsh = 4'hF;

  sequence_generator dut (.clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .pattern(pattern), .len(len), .rpt(rpt), .abort(abort), .x(x), .x_valid(x_valid), .sof(sof), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a bit or a done pulse
  always @(negedge clk) begin
    if (cyc >= 1) begin
      while (q.size() != 0 && q[0].cyc < cyc) begin
        chk("missing_output", 0, 1);
        void'(q.pop_front());
      end
      chk("load_ready", int'(load_ready), int'(!rst && !(cyc >= act_s && cyc < act_e)));
      if (x_valid || done) begin
        if (q.size() == 0 || q[0].cyc != cyc) chk("unexpected_output", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done", int'(done), int'(e.dn));
          chk("x_valid", int'(x_valid), int'(!e.dn));
          chk("x", int'(x), int'(e.xb));
          chk("sof", int'(sof), int'(e.sb));
        end
      end else begin
        chk("idle_x", int'(x), 0);
        chk("idle_sof", int'(sof), 0);
      end
      if (rst) dsh = 4'hF;
      else if (x_valid) begin
        dsh = {dsh[2:0], x};
        if (dsh == 4'b0110) det++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!load_ready) begin
      step();
      if (++t > 400) begin
        chk("idle_timeout", 0, 1);
        summary();
      end
    end
  endtask

  // reference model: a load accepted on the coming edge produces bit k of pass p at ec+p*(L+G)+k
  task automatic issue(input logic [W-1:0] p, input int l, input int r);
    int lf, dc;
    wait_idle();
    pattern = p;
    len = l[4:0];
    rpt = r[3:0];
    load_valid = 1'b1;
    ec = cyc + 1;
    lf = (len == 0 || len > 16) ? 16 : int'(len);
    for (int ps = 0; ps <= r; ps++)
      for (int k = 0; k < lf; k++)
        q.push_back('{ec + ps * (lf + G) + k, 1'b0, p[k], k == 0});
    dc = ec + (r + 1) * lf + r * G;
    q.push_back('{dc, 1'b1, 1'b0, 1'b0});
    act_s = ec;
    act_e = dc;
  endtask

  task automatic release_load();
    step();
    load_valid = 1'b0;
    pattern = W'($urandom);
    len = 5'($urandom);
    rpt = 4'($urandom);
  endtask

  task automatic cut_at(input int n);
    while (q.size() != 0 && q[$].cyc > n) void'(q.pop_back());
    act_e = n + 1;
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    int d0, dc;
    repeat (3) step();
    rst = 1'b0;
    step();
    issue(16'h0006, 4, 0);
    release_load();
    issue(16'h0006, 4, 2);
    release_load();
    issue(16'hA5C3, 0, 0);
    release_load();
    issue(16'hA5C3, 20, 0);
    release_load();
    issue(16'h1234, 7, 3);
    release_load();
    goto_cyc(ec + (7 + G) + 2);
    abort = 1'b1;
    cut_at(cyc);
    step();
    abort = 1'b0;
    issue(16'h0006, 4, 0);
    release_load();
    issue(16'h00F5, 4, 2);
    release_load();
    goto_cyc(ec + 4);
    rst = 1'b1;
    cut_at(cyc);
    step();
    rst = 1'b0;
    step();
    d0 = det;
    issue(16'h0006, 4, 0);
    step();
    issue(16'h0006, 4, 0);
    release_load();
    wait_idle();
    step();
    chk("detector_hits", det - d0, 2);
    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), $urandom_range(0, 20), $urandom_range(0, 3));
      dc = act_e;
      release_load();
      if ($urandom_range(0, 3) == 0) begin
        goto_cyc(ec + $urandom_range(0, dc - ec - 2));
        abort = 1'b1;
        cut_at(cyc);
        step();
        abort = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle();
    repeat (3) step();
    chk("queue_drained", q.size(), 0);
    summary();
  end
endmodule
